// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with same-cycle write bypass,
// a hardwired zero register and a per-register pending-write scoreboard.
// Reads are combinational; storage, pending bits and the pending count
// update on the rising edge of Clk. Reset is synchronous and active-high.
module regfile_sb #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_IDX   = 31,
  parameter int BYPASS     = 1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] RA,
  output logic [NUM_READ*DATA_WIDTH-1:0] BusR,
  output logic [NUM_READ-1:0]            RReady,
  input  logic [ADDR_WIDTH-1:0]          RW,
  input  logic [DATA_WIDTH-1:0]          BusW,
  input  logic                           RegWr,
  input  logic [ADDR_WIDTH-1:0]          RsvIdx,
  input  logic                           RsvEn,
  output logic [ADDR_WIDTH:0]            PendingCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(ZERO_IDX);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      pending_q;
  logic [DEPTH-1:0]      pending_d;
  logic [ADDR_WIDTH:0]   pend_cnt_q;
  logic [ADDR_WIDTH:0]   pend_cnt_d;

  logic wr_ok;
  logic rsv_ok;
  logic cnt_inc;
  logic cnt_dec;

  // Writes and reserves aimed at the zero register are dropped here so that
  // nothing downstream has to special-case it.
  always_comb begin
    wr_ok  = RegWr && (RW != ZERO_A);
    rsv_ok = RsvEn && (RsvIdx != ZERO_A);
  end

  // Next storage contents: a qualified write replaces one entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_ok) begin
      regs_d[RW] = BusW;
    end
  end

  // Next pending bits: writeback clears, reserve sets; the reserve is applied
  // last so a new producer on the same index wins over the retiring one.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok) begin
      pending_d[RW] = 1'b0;
    end
    if (rsv_ok) begin
      pending_d[RsvIdx] = 1'b1;
    end
  end

  // Incremental count: at most one bit can set and one can clear per cycle,
  // so a +1/-1 adjust tracks the popcount without an adder tree.
  always_comb begin
    cnt_inc = rsv_ok && !pending_q[RsvIdx];
    cnt_dec = wr_ok && pending_q[RW] && !(rsv_ok && (RsvIdx == RW));
    pend_cnt_d = pend_cnt_q + (ADDR_WIDTH + 1)'(cnt_inc) - (ADDR_WIDTH + 1)'(cnt_dec);
  end

  // State registers with synchronous reset that overrides write and reserve.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Read ports: zero register first, then same-cycle forward, then storage.
  // A same-cycle reserve is deliberately not visible until the next cycle.
  always_comb begin
    BusR   = '0;
    RReady = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      if (RA[p*ADDR_WIDTH +: ADDR_WIDTH] == ZERO_A) begin
        BusR[p*DATA_WIDTH +: DATA_WIDTH] = '0;
        RReady[p]                        = 1'b1;
      end else if ((BYPASS != 0) && RegWr && (RW == RA[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
        BusR[p*DATA_WIDTH +: DATA_WIDTH] = BusW;
        RReady[p]                        = 1'b1;
      end else begin
        BusR[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[RA[p*ADDR_WIDTH +: ADDR_WIDTH]];
        RReady[p]                        = !pending_q[RA[p*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  assign PendingCount = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (bypass on / bypass off) share one
// stimulus stream and are compared against an array-based reference model.
module tb_regfile_sb;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int ZI = 31;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [NR*AW-1:0] RA;
  logic [AW-1:0] RW;
  logic [AW-1:0] RsvIdx;
  logic [DW-1:0] BusW;
  logic          RegWr;
  logic          RsvEn;

  logic [NR*DW-1:0] busr_b, busr_n;
  logic [NR-1:0]    rdy_b, rdy_n;
  logic [AW:0]      cnt_b, cnt_n;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_regs [32];
  bit            m_pend [32];

  always #5 Clk = ~Clk;

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_IDX(ZI), .BYPASS(1)) u_byp (
    .Clk(Clk), .Reset(Reset), .RA(RA), .BusR(busr_b), .RReady(rdy_b),
    .RW(RW), .BusW(BusW), .RegWr(RegWr), .RsvIdx(RsvIdx), .RsvEn(RsvEn),
    .PendingCount(cnt_b)
  );

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_IDX(ZI), .BYPASS(0)) u_nob (
    .Clk(Clk), .Reset(Reset), .RA(RA), .BusR(busr_n), .RReady(rdy_n),
    .RW(RW), .BusW(BusW), .RegWr(RegWr), .RsvIdx(RsvIdx), .RsvEn(RsvEn),
    .PendingCount(cnt_n)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_pend[i] ? 1 : 0;
    return n;
  endfunction

  // Compare the combinational read outputs and the registered count.
  task automatic check_outputs();
    logic [AW-1:0] ra;
    logic [DW-1:0] d_b, d_n;
    logic          r_b, r_n;
    for (int p = 0; p < NR; p++) begin
      ra = RA[p*AW +: AW];
      if (ra == ZI) begin
        d_b = '0; r_b = 1'b1; d_n = '0; r_n = 1'b1;
      end else begin
        d_n = m_regs[ra];
        r_n = !m_pend[ra];
        if (RegWr && RW == ra) begin
          d_b = BusW; r_b = 1'b1;
        end else begin
          d_b = d_n; r_b = r_n;
        end
      end
      chk($sformatf("byp_busr%0d_ra%0d", p, ra), busr_b[p*DW +: DW], d_b);
      chk($sformatf("byp_rdy%0d_ra%0d", p, ra), 64'(rdy_b[p]), 64'(r_b));
      chk($sformatf("nob_busr%0d_ra%0d", p, ra), busr_n[p*DW +: DW], d_n);
      chk($sformatf("nob_rdy%0d_ra%0d", p, ra), 64'(rdy_n[p]), 64'(r_n));
    end
    chk("byp_pendcount", 64'(cnt_b), 64'(model_count()));
    chk("nob_pendcount", 64'(cnt_n), 64'(model_count()));
  endtask

  task automatic model_update();
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (RegWr && RW != ZI) begin
        m_regs[RW] = BusW;
        m_pend[RW] = 1'b0;
      end
      if (RsvEn && RsvIdx != ZI) m_pend[RsvIdx] = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge Clk);
    check_outputs();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  task automatic drive(input int ra0, input int ra1, input bit wr, input int rw,
                       input logic [DW-1:0] bw, input bit rsv, input int ri, input bit rst);
    RA     = {AW'(ra1), AW'(ra0)};
    RegWr  = wr;
    RW     = AW'(rw);
    BusW   = bw;
    RsvEn  = rsv;
    RsvIdx = AW'(ri);
    Reset  = rst;
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    RA = '0; RW = '0; RsvIdx = '0; BusW = '0; RegWr = 1'b0; RsvEn = 1'b0;
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Post-reset sweep of every index on both ports.
    for (int i = 0; i < 32; i++) drive(i, 31 - i, 0, 0, '0, 0, 0, 0);

    // Write X5: bypass instance forwards in the write cycle, other does not.
    drive(5, 5, 1, 5, 64'hDEAD_BEEF_0123_4567, 0, 0, 0);
    drive(5, 0, 0, 0, '0, 0, 0, 0);
    chk("x5_after_write", busr_n[DW-1:0], 64'hDEAD_BEEF_0123_4567);

    // Zero register: write and reserve are both ignored.
    drive(31, 31, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 31, 0);
    drive(31, 31, 0, 0, '0, 0, 0, 0);
    chk("xzr_count", 64'(cnt_b), 64'd0);

    // Reserve X3, X7, X3 then writeback X3.
    drive(3, 7, 0, 0, '0, 1, 3, 0);
    chk("rsv_cnt1", 64'(cnt_b), 64'd1);
    drive(3, 7, 0, 0, '0, 1, 7, 0);
    chk("rsv_cnt2", 64'(cnt_b), 64'd2);
    chk("rsv_x3_rdy_low", 64'(rdy_b[0]), 64'd0);
    drive(3, 7, 0, 0, '0, 1, 3, 0);
    chk("rsv_cnt2_again", 64'(cnt_b), 64'd2);
    drive(3, 7, 1, 3, 64'h77, 0, 0, 0);
    chk("wb_x3_cnt", 64'(cnt_b), 64'd1);
    drive(3, 7, 0, 0, '0, 0, 0, 0);

    // Simultaneous write and reserve of X9: data lands, pending stays set.
    drive(9, 9, 1, 9, 64'h42, 1, 9, 0);
    chk("x9_cnt", 64'(cnt_b), 64'd2);
    drive(9, 1, 0, 0, '0, 0, 0, 0);
    chk("x9_data", busr_b[DW-1:0], 64'h42);
    chk("x9_rdy", 64'(rdy_b[0]), 64'd0);

    // Reservations and a write, then reset with a colliding write.
    drive(1, 2, 0, 0, '0, 1, 1, 0);
    drive(1, 2, 0, 0, '0, 1, 2, 0);
    drive(4, 1, 1, 4, 64'h10, 0, 0, 0);
    drive(4, 1, 1, 4, 64'h20, 1, 4, 1);
    chk("rst_cnt", 64'(cnt_b), 64'd0);
    chk("rst_x4", busr_n[DW-1:0], 64'd0);
    for (int i = 0; i < 32; i++) drive(i, (i * 7) % 32, 0, 0, '0, 0, 0, 0);

    // Randomized traffic, biased so reads often collide with the write index.
    for (int n = 0; n < 3000; n++) begin
      int rw, ra0, ra1, ri;
      rw  = $urandom_range(0, 31);
      ri  = ($urandom_range(0, 3) == 0) ? rw : $urandom_range(0, 31);
      ra0 = ($urandom_range(0, 3) == 0) ? rw : $urandom_range(0, 31);
      ra1 = ($urandom_range(0, 3) == 0) ? ri : $urandom_range(0, 31);
      drive(ra0, ra1, $urandom_range(0, 1) == 1, rw, {$urandom, $urandom},
            $urandom_range(0, 1) == 1, ri, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
